// File: rtl/lsu_mem_sequencer_if.sv
// Data-memory bus between the load/store sequencer (master) and memory (slave).
// Single outstanding request: busReq is held until a one-cycle busAck.
interface lsu_mem_sequencer_if #(
  parameter int cXLEN = 32
);
  logic               busReq;
  logic               busWe;
  logic [cXLEN-1:0]   busAddr;
  logic [cXLEN-1:0]   busWdata;
  logic [cXLEN/8-1:0] busBe;
  logic [cXLEN-1:0]   busRdata;
  logic               busAck;
  logic               busErr;

  modport master (
    output busReq, busWe, busAddr, busWdata, busBe, busErr,
    input  busRdata, busAck
  );

  modport slave (
    input  busReq, busWe, busAddr, busWdata, busBe, busErr,
    output busRdata, busAck
  );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between the ALU stage and the writeback mux.
// Takes the tMemOp record, runs one bus transaction at a time, stalls the
// pipeline while busy, steers store lanes and sign/zero-extends loads.
// Optional feature macro MISALIGN_TRAP_EN: misaligned half/word accesses
// skip the bus and raise a one-cycle misalign pulse instead.
// tMemOp  = {read, write, addr[31:0], data[31:0], opType[2:0], rdAddr[4:0]}
// tRegOp  = {dv, addr[4:0], data[31:0]}
module lsu_mem_sequencer #(
  parameter int cXLEN       = 32,
  parameter int cBusTimeout = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*cXLEN+9:0]   memOpIn,
  output logic                 stall,
  output logic [cXLEN+5:0]     regOpOut,
`ifdef MISALIGN_TRAP_EN
  output logic                 misalign,
`endif
  lsu_mem_sequencer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state_q, state_d;

  logic             mem_rd, mem_wr, op_valid;
  logic [cXLEN-1:0] mem_addr, mem_data;
  logic [2:0]       mem_type;
  logic [4:0]       mem_rdaddr;
  logic [1:0]       mem_sz;

  logic             accept, trap, ack_ok, expire;
  logic [7:0]       cnt_q;

  // latched operation
  logic             op_we_q, op_uns_q;
  logic [1:0]       op_sz_q, op_lane_q;
  logic [4:0]       op_rd_q;

  assign mem_rd     = memOpIn[2*cXLEN+9];
  assign mem_wr     = memOpIn[2*cXLEN+8];
  assign mem_addr   = memOpIn[2*cXLEN+7 -: cXLEN];
  assign mem_data   = memOpIn[cXLEN+7 -: cXLEN];
  assign mem_type   = memOpIn[7:5];
  assign mem_rdaddr = memOpIn[4:0];
  assign op_valid   = mem_rd | mem_wr;

  // Access size: 00 byte, 01 half, 10 word; undefined encodings fall to word.
  function automatic logic [1:0] size_of(input logic [2:0] t);
    return (t[1:0] == 2'b11) ? 2'b10 : t[1:0];
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << {lane[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/half out of the returned word and extend it.
  function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] lane, input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a != 2'b00));
  endfunction
  assign trap = misaligned(mem_sz, mem_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign mem_sz = size_of(mem_type);
  assign ack_ok = (state_q == REQ) && bus.busAck;
  assign expire = (state_q == REQ) && !bus.busAck && (cnt_q == 8'(cBusTimeout - 1));

  // Next-state and stall decode; stall rises combinationally on acceptance.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          stall   = 1'b1;
          accept  = 1'b1;
          state_d = trap ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (ack_ok || expire) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, bus drive, timeout counter and writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      bus.busReq   <= 1'b0;
      bus.busWe    <= 1'b0;
      bus.busAddr  <= '0;
      bus.busWdata <= '0;
      bus.busBe    <= '0;
      bus.busErr   <= 1'b0;
      regOpOut     <= '0;
      op_we_q      <= 1'b0;
      op_uns_q     <= 1'b0;
      op_sz_q      <= 2'b00;
      op_lane_q    <= 2'b00;
      op_rd_q      <= 5'd0;
`ifdef MISALIGN_TRAP_EN
      misalign     <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      bus.busErr       <= 1'b0;
      regOpOut[cXLEN+5] <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign         <= accept && trap;
`endif
      if (accept) begin
        cnt_q     <= 8'd0;
        op_we_q   <= mem_wr;
        op_uns_q  <= mem_type[2];
        op_sz_q   <= mem_sz;
        op_lane_q <= mem_addr[1:0];
        op_rd_q   <= mem_rdaddr;
        if (!trap) begin
          bus.busReq   <= 1'b1;
          bus.busWe    <= mem_wr;
          bus.busAddr  <= {mem_addr[cXLEN-1:2], 2'b00};
          bus.busWdata <= wdata_of(mem_sz, mem_data);
          bus.busBe    <= be_of(mem_sz, mem_addr[1:0]);
        end
      end
      if (state_q == REQ) begin
        cnt_q <= cnt_q + 8'd1;
        if (ack_ok) begin
          bus.busReq <= 1'b0;
          if (!op_we_q)
            regOpOut <= {(op_rd_q != 5'd0), op_rd_q,
                         load_ext(op_sz_q, op_uns_q, op_lane_q, bus.busRdata)};
        end else if (expire) begin
          bus.busReq <= 1'b0;
          bus.busErr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: directed cases followed by randomized
// transactions, checked against a size/offset arithmetic reference model.
module tb_lsu_mem_sequencer;
  localparam int XLEN = 32;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [73:0] memOpIn;
  logic        stall;
  logic [37:0] regOpOut;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  lsu_mem_sequencer_if #(.cXLEN(XLEN)) bus ();

  lsu_mem_sequencer #(.cXLEN(XLEN), .cBusTimeout(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .memOpIn  (memOpIn),
    .stall    (stall),
    .regOpOut (regOpOut),
`ifdef MISALIGN_TRAP_EN
    .misalign (misalign),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] t);
    if (t == 3'b000 || t == 3'b100) return 1;
    if (t == 3'b001 || t == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit is_trap(input logic [2:0] t, input logic [31:0] a);
    int nb = nbytes(t);
    return TRAP && ((nb == 2 && (a % 2) != 0) || (nb == 4 && (a % 4) != 0));
  endfunction

  function automatic int offset(input logic [2:0] t, input logic [31:0] a);
    int nb = nbytes(t);
    if (nb == 1) return int'(a % 4);
    if (nb == 2) return int'(a % 4) / 2 * 2;
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] t, input logic [31:0] a);
    int nb = nbytes(t);
    return 4'(((1 << nb) - 1) << offset(t, a));
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] t, input logic [31:0] d);
    int nb = nbytes(t);
    if (nb == 1) return (d % 256) * 32'h0101_0101;
    if (nb == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] rdata);
    int          nb = nbytes(t);
    logic [31:0] mask, v;
    if (nb == 4) return rdata;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = (rdata >> (8 * offset(t, a))) & mask;
    if (!t[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // ------------- one transaction with a responding bus slave -------------
  // ack_at: REQ cycle (1-based) on which busAck is given; 0 or >TMO = never.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] ty, input logic [4:0] rda,
                        input int ack_at, input logic [31:0] rdata,
                        output logic [31:0] o_data, output logic [3:0] o_be,
                        output logic [31:0] o_wd);
    int          stall_n = 0, req_n = 0, err_n = 0, dv_n = 0, mis_n = 0;
    bit          done = 0;
    bit          trap = is_trap(ty, addr);
    bit          acked = !trap && ack_at >= 1 && ack_at <= TMO;
    int          exp_req = trap ? 0 : (acked ? ack_at : TMO);
    bit          exp_dv = acked && !wr && rda != 5'd0;
    logic [37:0] reg_done = 'x;
    logic        we_s = 1'bx;
    logic [31:0] addr_s = 'x, wd_s = 'x;
    logic [3:0]  be_s = 'x;

    @(posedge clk);
    #1;
    memOpIn      = {rd, wr, addr, data, ty, rda};
    bus.busRdata = rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (bus.busReq) begin
        req_n++;
        if (req_n == 1) begin
          we_s = bus.busWe; addr_s = bus.busAddr; be_s = bus.busBe; wd_s = bus.busWdata;
        end
      end
      if (bus.busErr) err_n++;
      if (regOpOut[37]) dv_n++;
`ifdef MISALIGN_TRAP_EN
      if (misalign) mis_n++;
`endif
      bus.busAck = bus.busReq && (req_n == ack_at);
      if (!stall) begin
        done       = 1;
        reg_done   = regOpOut;
        memOpIn    = '0;
        bus.busAck = 1'($urandom_range(0, 1));
      end
    end
    check({tag, "_complete"}, done, 1);
    @(negedge clk);
    check({tag, "_idle_dv"}, regOpOut[37], 0);
    check({tag, "_idle_stall"}, stall, 0);
    check({tag, "_idle_req"}, bus.busReq, 0);
    check({tag, "_idle_err"}, bus.busErr, 0);
    bus.busAck = 1'b0;

    check({tag, "_stall_cycles"}, stall_n, trap ? 1 : 1 + exp_req);
    check({tag, "_req_cycles"}, req_n, exp_req);
    check({tag, "_err_pulses"}, err_n, (trap || acked) ? 0 : 1);
    check({tag, "_dv_pulses"}, dv_n, exp_dv);
    check({tag, "_misalign"}, mis_n, trap);
    if (exp_req > 0) begin
      check({tag, "_we"}, we_s, wr);
      check({tag, "_addr"}, addr_s, {addr[31:2], 2'b00});
      check({tag, "_be"}, be_s, model_be(ty, addr));
      if (wr) check({tag, "_wdata"}, wd_s, model_wd(ty, data));
    end
    if (exp_dv) check({tag, "_wb"}, reg_done[36:0], {rda, model_ld(ty, addr, rdata)});
    o_data = reg_done[31:0];
    o_be   = be_s;
    o_wd   = wd_s;
  endtask

  logic [31:0] od, ow;
  logic [3:0]  ob;

  initial begin
    rst          = 1'b1;
    memOpIn      = '0;
    bus.busAck   = 1'b0;
    bus.busRdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_regop", regOpOut, 0);
    check("rst_req", bus.busReq, 0);
    check("rst_we", bus.busWe, 0);
    check("rst_addr", bus.busAddr, 0);
    check("rst_wdata", bus.busWdata, 0);
    check("rst_be", bus.busBe, 0);
    check("rst_err", bus.busErr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_op("lw", 1, 0, 32'h100, 32'h0, 3'b010, 5'd7, 1, 32'hDEADBEEF, od, ob, ow);
    check("lw_data", od, 32'hDEADBEEF);
    check("lw_be", ob, 4'b1111);
    run_op("lb", 1, 0, 32'h103, 32'h0, 3'b000, 5'd3, 2, 32'h80FF_FF00, od, ob, ow);
    check("lb_data", od, 32'hFFFFFF80);
    run_op("lbu", 1, 0, 32'h103, 32'h0, 3'b100, 5'd3, 1, 32'h80FF_FF00, od, ob, ow);
    check("lbu_data", od, 32'h00000080);
    run_op("lh", 1, 0, 32'h102, 32'h0, 3'b001, 5'd9, 3, 32'h80FF_FF00, od, ob, ow);
    check("lh_data", od, 32'hFFFF80FF);
    run_op("lhu", 1, 0, 32'h102, 32'h0, 3'b101, 5'd9, 1, 32'h80FF_FF00, od, ob, ow);
    check("lhu_data", od, 32'h000080FF);
    run_op("sb", 0, 1, 32'h21, 32'h12345678, 3'b000, 5'd4, 1, 32'h0, od, ob, ow);
    check("sb_be", ob, 4'b0010);
    check("sb_wdata", ow, 32'h78787878);
    run_op("rw_store", 1, 1, 32'h42, 32'hCAFE1234, 3'b001, 5'd6, 2, 32'h55AA55AA, od, ob, ow);
    run_op("timeout", 1, 0, 32'h200, 32'h0, 3'b010, 5'd5, 0, 32'h11111111, od, ob, ow);
    run_op("ack16", 1, 0, 32'h204, 32'h0, 3'b010, 5'd5, TMO, 32'h22222222, od, ob, ow);
    check("ack16_data", od, 32'h22222222);
    run_op("lw_rd0", 1, 0, 32'h300, 32'h0, 3'b010, 5'd0, 1, 32'h33333333, od, ob, ow);
    run_op("lw_mis", 1, 0, 32'h102, 32'h0, 3'b010, 5'd8, 1, 32'h44445555, od, ob, ow);
    run_op("undef_op", 1, 0, 32'h10, 32'h0, 3'b111, 5'd2, 1, 32'h89ABCDEF, od, ob, ow);

    // reset while a request is outstanding
    @(posedge clk);
    #1 memOpIn = {1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 5'd1};
    @(negedge clk);
    @(negedge clk);
    check("midrst_req_before", bus.busReq, 1);
    rst     = 1'b1;
    memOpIn = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_req", bus.busReq, 0);
    check("midrst_stall", stall, 0);
    check("midrst_dv", regOpOut[37], 0);
    run_op("post_rst_lw", 1, 0, 32'h404, 32'h0, 3'b010, 5'd1, 1, 32'h0BADF00D, od, ob, ow);
    check("post_rst_data", od, 32'h0BADF00D);

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      int          sel = $urandom_range(0, 3);
      int          r   = $urandom_range(0, 9);
      int          ack;
      logic        rd = (sel != 2);
      logic        wr = (sel >= 2);
      logic [31:0] a  = $urandom;
      logic [31:0] d  = $urandom;
      logic [31:0] rv = $urandom;
      logic [2:0]  ty = 3'($urandom_range(0, 7));
      logic [4:0]  rn = 5'($urandom_range(0, 31));
      ack = (r == 0) ? 0 : ((r == 1) ? TMO : $urandom_range(1, 4));
      run_op("rand", rd, wr, a, d, ty, rn, ack, rv, od, ob, ow);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
